// File: rtl/status_cond_ctrl_if.sv
// ----------------------------------------------------------------------------
// status_cond_ctrl_if
//   Bundles the ID-stage handshake, the EX flag-write port and the status
//   outputs of status_cond_ctrl into one interface.
//
//   master : pipeline side; drives the ID instruction, the flush and the EX
//            flag write, and observes id_ready/id_exec and the status outputs.
//   slave  : status_cond_ctrl side.
//
//   Signals
//     id_valid       instruction present in ID
//     id_cond        condition field of the ID instruction
//     id_sets_flags  S bit of the ID instruction
//     flush          branch taken in EX, kills the ID instruction this cycle
//     ex_flag_valid  EX writes flags this cycle
//     ex_flags       new flags {z,c,n,v}
//     id_ready       ID instruction may advance this cycle
//     id_exec        ID instruction advances with its condition passed
//     stat_reg       architectural flags {z,c,n,v}
//     pending        flag-setting instructions in flight
//     err            sticky {timeout, underflow}
// ----------------------------------------------------------------------------
interface status_cond_ctrl_if #(
    parameter int MAX_PENDING = 2
);
    localparam int CONDITION_LEN  = 4;
    localparam int STATUS_REG_LEN = 4;
    localparam int PEND_W         = $clog2(MAX_PENDING + 1);

    logic                      id_valid;
    logic [CONDITION_LEN-1:0]  id_cond;
    logic                      id_sets_flags;
    logic                      flush;
    logic                      ex_flag_valid;
    logic [STATUS_REG_LEN-1:0] ex_flags;
    logic                      id_ready;
    logic                      id_exec;
    logic [STATUS_REG_LEN-1:0] stat_reg;
    logic [PEND_W-1:0]         pending;
    logic [1:0]                err;

    modport master (
        output id_valid, id_cond, id_sets_flags, flush, ex_flag_valid, ex_flags,
        input  id_ready, id_exec, stat_reg, pending, err
    );

    modport slave (
        input  id_valid, id_cond, id_sets_flags, flush, ex_flag_valid, ex_flags,
        output id_ready, id_exec, stat_reg, pending, err
    );
endinterface

// File: rtl/status_cond_ctrl.sv
// ----------------------------------------------------------------------------
// status_cond_ctrl
//   Condition-code evaluation and flag-hazard interlock for the ID stage.
//   Evaluates the ID instruction's condition against the current flags
//   (forwarding a same-cycle EX flag write), stalls conditional instructions
//   while flag writers are still in flight, limits the number of in-flight
//   flag writers, and watches for over-long stalls and spurious flag writes.
//
//   Ports
//     clk   single clock, rising edge
//     rst   asynchronous, active-low reset
//     bus   status_cond_ctrl_if.slave (see interface for signal list)
//
//   Parameters
//     MAX_PENDING  maximum flag-setting instructions between ID and EX write
//     WAIT_LIMIT   consecutive stall cycles that raise the timeout error
// ----------------------------------------------------------------------------
module status_cond_ctrl #(
    parameter int MAX_PENDING = 2,
    parameter int WAIT_LIMIT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    status_cond_ctrl_if.slave  bus
);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam int CNT_W  = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  stall_cnt, stall_cnt_d;
    logic [3:0]        stat_reg;
    logic [PEND_W-1:0] pending, pending_d;
    logic [1:0]        err;

    logic [3:0] eval_flags;
    logic       z, c, n, v;
    logic       cond_pass;
    logic       flag_hazard;
    logic       full;
    logic       id_ready;
    logic       accept;
    logic       id_exec;
    logic       underflow;
    logic       timeout;
    logic       stall;

    // Same-cycle forwarding: a flag write in EX is visible to the ID condition.
    assign eval_flags = bus.ex_flag_valid ? bus.ex_flags : stat_reg;
    assign {z, c, n, v} = eval_flags;

    always_comb begin
        case (bus.id_cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // A writer retiring this cycle is already forwarded, so only writers
    // beyond it block a conditional instruction.
    assign flag_hazard = (bus.id_cond != 4'b1110) &&
                         (pending > PEND_W'(bus.ex_flag_valid));
    assign full        = bus.id_sets_flags && (pending == PEND_W'(MAX_PENDING)) &&
                         !bus.ex_flag_valid;

    // Held low while reset is asserted so nothing advances out of reset.
    assign id_ready = rst & bus.id_valid & ~flag_hazard & ~full;
    assign accept   = id_ready & ~bus.flush;
    assign id_exec  = accept & cond_pass;

    assign underflow = bus.ex_flag_valid && (pending == '0);
    assign stall     = bus.id_valid & ~id_ready & ~bus.flush;

    // A flag write with nothing in flight saturates at zero, even if a new
    // writer is accepted in the same cycle.
    always_comb begin
        if (underflow) begin
            pending_d = '0;
        end else begin
            pending_d = pending + PEND_W'(id_exec & bus.id_sets_flags)
                                - PEND_W'(bus.ex_flag_valid);
        end
    end

    // stall_cnt holds the number of consecutive stalled cycles already seen;
    // the stalled RUN cycle that enters WAIT is the first one.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state;
        stall_cnt_d = stall_cnt;
        timeout     = 1'b0;
        case (state)
            RUN: begin
                stall_cnt_d = '0;
                if (stall) begin
                    state_d     = WAIT;
                    stall_cnt_d = CNT_W'(1);
                end
            end
            WAIT: begin
                if (!stall) begin
                    state_d     = RUN;
                    stall_cnt_d = '0;
                end else if (stall_cnt + CNT_W'(1) == CNT_W'(WAIT_LIMIT)) begin
                    state_d     = ERR;
                    stall_cnt_d = '0;
                    timeout     = 1'b1;
                end else begin
                    stall_cnt_d = stall_cnt + CNT_W'(1);
                end
            end
            ERR: begin
                // Datapath keeps running; only reset leaves this state.
                stall_cnt_d = '0;
            end
            default: begin
                state_d     = RUN;
                stall_cnt_d = '0;
            end
        endcase
    end

    // NOTE: only control/status registers exist here; all are reset asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            stall_cnt <= '0;
            stat_reg  <= '0;
            pending   <= '0;
            err       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state     <= state_d;
            stall_cnt <= stall_cnt_d;
            pending   <= pending_d;
            err       <= err | {timeout, underflow};
            if (bus.ex_flag_valid) begin
                stat_reg <= bus.ex_flags;
            end
        end
    end

    assign bus.id_ready = id_ready;
    assign bus.id_exec  = id_exec;
    assign bus.stat_reg = stat_reg;
    assign bus.pending  = pending;
    assign bus.err      = err;
endmodule

// File: tb/tb_status_cond_ctrl.sv
// ----------------------------------------------------------------------------
// tb_status_cond_ctrl
//   Directed bench for status_cond_ctrl: reset behaviour, flag hazard with
//   forwarding, pending limit, stall timeout, underflow, flush, a full
//   condition/flag sweep and reset in the middle of a stall.
// ----------------------------------------------------------------------------
module tb_status_cond_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    status_cond_ctrl_if #(.MAX_PENDING(2)) bus ();

    status_cond_ctrl #(
        .MAX_PENDING (2),
        .WAIT_LIMIT  (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] cnd, input logic s,
                         input logic fl, input logic efv, input logic [3:0] f);
        bus.id_valid      = v;
        bus.id_cond       = cnd;
        bus.id_sets_flags = s;
        bus.flush         = fl;
        bus.ex_flag_valid = efv;
        bus.ex_flags      = f;
    endtask

    // Condition table written out from the flag meanings {z,c,n,v}.
    function automatic logic cond_model(input logic [3:0] cnd, input logic [3:0] f);
        logic z, c, n, v;
        z = f[3]; c = f[2]; n = f[1]; v = f[0];
        case (cnd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        drive(1, 4'b1110, 1, 0, 0, 4'h0);

        // Reset: outputs forced, nothing advances even across a clock edge.
        #2;
        check("rst_ready", bus.id_ready, 0);
        check("rst_exec",  bus.id_exec,  0);
        check("rst_stat",  bus.stat_reg, 0);
        check("rst_pend",  bus.pending,  0);
        check("rst_err",   bus.err,      0);
        @(negedge clk); #1;
        check("rst_pend_edge", bus.pending, 0);

        // Basic evaluation: EQ fails with z=0, AL executes.
        rst = 1'b1;
        drive(1, 4'b0000, 0, 0, 0, 4'h0); #1;
        check("eq_ready", bus.id_ready, 1);
        check("eq_exec",  bus.id_exec,  0);
        drive(1, 4'b1110, 0, 0, 0, 4'h0); #1;
        check("al_exec",  bus.id_exec,  1);

        // ADDS then BEQ: stall, then forwarded flag write releases it.
        @(negedge clk); drive(1, 4'b1110, 1, 0, 0, 4'h0); #1;
        check("adds_exec", bus.id_exec, 1);
        @(negedge clk); drive(1, 4'b0000, 0, 0, 0, 4'h0); #1;
        check("beq_pend",  bus.pending,  1);
        check("beq_stall", bus.id_ready, 0);
        check("beq_noexec", bus.id_exec, 0);
        @(negedge clk); drive(1, 4'b0000, 0, 0, 1, 4'b1000); #1;
        check("fwd_ready", bus.id_ready, 1);
        check("fwd_exec",  bus.id_exec,  1);
        @(negedge clk); drive(0, 4'b0000, 0, 0, 0, 4'h0); #1;
        check("fwd_stat", bus.stat_reg, 8'b1000);
        check("fwd_pend", bus.pending,  0);

        // Pending limit: two writers in flight, third waits for a retire.
        @(negedge clk); drive(1, 4'b1110, 1, 0, 0, 4'h0); #1;
        check("s1_exec", bus.id_exec, 1);
        @(negedge clk); #1;
        check("s2_pend", bus.pending, 1);
        check("s2_exec", bus.id_exec, 1);
        @(negedge clk); #1;
        check("s3_pend",  bus.pending,  2);
        check("s3_full",  bus.id_ready, 0);
        @(negedge clk); drive(1, 4'b1110, 1, 0, 1, 4'b0100); #1;
        check("s3_ready", bus.id_ready, 1);
        check("s3_exec",  bus.id_exec,  1);
        @(negedge clk); drive(0, 4'b0000, 0, 0, 1, 4'b0010); #1;
        check("s3_pend_hold", bus.pending,  2);
        check("s3_stat",      bus.stat_reg, 8'b0100);
        @(negedge clk); #1;
        check("drain1_pend", bus.pending, 1);
        @(negedge clk); drive(0, 4'b0000, 0, 0, 0, 4'h0); #1;
        check("drain2_pend", bus.pending,  0);
        check("drain_stat",  bus.stat_reg, 8'b0010);
        check("drain_err",   bus.err,      0);

        // Timeout: 15 consecutive stall cycles raise err[1].
        @(negedge clk); drive(1, 4'b1110, 1, 0, 0, 4'h0); #1;
        check("to_adds", bus.id_exec, 1);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk); drive(1, 4'b0000, 0, 0, 0, 4'h0); #1;
            check("to_stall", bus.id_ready, 0);
            if (i == 15) check("to_err_before", bus.err, 0);
        end
        @(negedge clk); drive(1, 4'b0000, 0, 0, 1, 4'b1000); #1;
        check("to_err",   bus.err,      8'b10);
        check("to_ready", bus.id_ready, 1);
        check("to_exec",  bus.id_exec,  1);
        @(negedge clk); drive(1, 4'b0001, 0, 0, 0, 4'h0); #1;
        check("err_pend",   bus.pending,  0);
        check("err_stat",   bus.stat_reg, 8'b1000);
        check("err_ne",     bus.id_exec,  0);
        check("err_ready",  bus.id_ready, 1);
        drive(1, 4'b0000, 0, 0, 0, 4'h0); #1;
        check("err_eq",     bus.id_exec,  1);
        check("err_sticky", bus.err,      8'b10);

        // Underflow, then flush alone and flush with a retiring writer.
        @(negedge clk); drive(0, 4'b0000, 0, 0, 1, 4'b0110);
        @(negedge clk); drive(0, 4'b0000, 0, 0, 0, 4'h0); #1;
        check("uf_err",  bus.err,      8'b11);
        check("uf_pend", bus.pending,  0);
        check("uf_stat", bus.stat_reg, 8'b0110);
        @(negedge clk); drive(1, 4'b1110, 1, 1, 0, 4'h0); #1;
        check("fl_ready", bus.id_ready, 1);
        check("fl_exec",  bus.id_exec,  0);
        @(negedge clk); drive(1, 4'b1110, 1, 0, 0, 4'h0); #1;
        check("fl_pend", bus.pending, 0);
        check("fl_next", bus.id_exec, 1);
        @(negedge clk); drive(1, 4'b1110, 1, 1, 1, 4'b0001); #1;
        check("flex_pend1", bus.pending,  1);
        check("flex_ready", bus.id_ready, 1);
        check("flex_exec",  bus.id_exec,  0);
        @(negedge clk); drive(0, 4'b0000, 0, 0, 0, 4'h0); #1;
        check("flex_pend", bus.pending,  0);
        check("flex_stat", bus.stat_reg, 8'b0001);
        check("flex_err",  bus.err,      8'b11);

        // Sweep: every condition against every flag value, forwarded and registered.
        for (int f = 0; f < 16; f++) begin
            @(negedge clk); drive(1, 4'b0000, 0, 0, 1, 4'(f));
            for (int c = 0; c < 16; c++) begin
                bus.id_cond = 4'(c); #1;
                check("sweep_fwd", bus.id_exec, cond_model(4'(c), 4'(f)));
            end
            @(negedge clk); drive(1, 4'b0000, 0, 0, 0, 4'h0); #1;
            check("sweep_stat", bus.stat_reg, 8'(f));
            for (int c = 0; c < 16; c++) begin
                bus.id_cond = 4'(c); #1;
                check("sweep_reg", bus.id_exec, cond_model(4'(c), 4'(f)));
            end
        end

        // Reset clears sticky errors.
        @(negedge clk); drive(0, 4'b0000, 0, 0, 0, 4'h0); rst = 1'b0; #1;
        check("rst2_err",  bus.err,      0);
        check("rst2_stat", bus.stat_reg, 0);
        @(negedge clk); rst = 1'b1;

        // Reset in the middle of a stall discards it.
        drive(1, 4'b1110, 1, 0, 0, 4'h0); #1;
        check("ms_adds", bus.id_exec, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive(1, 4'b0000, 0, 0, 0, 4'h0);
        end
        @(negedge clk); #2; rst = 1'b0; #1;
        check("ms_pend",  bus.pending,  0);
        check("ms_ready", bus.id_ready, 0);
        check("ms_exec",  bus.id_exec,  0);
        @(negedge clk); rst = 1'b1; #1;
        check("ms_post_ready", bus.id_ready, 1);
        check("ms_post_exec",  bus.id_exec,  0);
        @(negedge clk); drive(1, 4'b1110, 1, 0, 0, 4'h0); #1;
        check("ms_adds2", bus.id_exec, 1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); drive(1, 4'b0000, 0, 0, 0, 4'h0); #1;
            check("ms_stall", bus.id_ready, 0);
        end
        @(negedge clk); drive(0, 4'b0000, 0, 0, 1, 4'h0); #1;
        check("ms_err", bus.err, 0);
        @(negedge clk); drive(0, 4'b0000, 0, 0, 0, 4'h0); #1;
        check("ms_end_pend", bus.pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
